// File: rtl/counter_arb_if.sv
// counter_arb_if: signal bundle between counter_arb and its requesters.
// Optional feature: define COUNTER_ARB_ABORT_EN to add the abort input.
// Signals:
//   req[1:0]        requests, bit i = requester i      (master -> slave)
//   len0, len1      burst lengths, sampled at grant     (master -> slave)
//   abort           cut the running burst short         (master -> slave, optional)
//   grant[1:0]      one-hot owner, 0 when idle          (slave -> master)
//   cnt_en          shared counter enable               (slave -> master)
//   count           shared counter value                (slave -> master)
//   done[1:0]       one-cycle end-of-burst pulse        (slave -> master)
//   busy            arbiter not idle                    (slave -> master)
interface counter_arb_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       grant;
    logic             cnt_en;
    logic [WIDTH-1:0] count;
    logic [1:0]       done;
    logic             busy;
`ifdef COUNTER_ARB_ABORT_EN
    logic             abort;
    modport master (output req, len0, len1, abort, input grant, cnt_en, count, done, busy);
    modport slave  (input req, len0, len1, abort, output grant, cnt_en, count, done, busy);
`else
    modport master (output req, len0, len1, input grant, cnt_en, count, done, busy);
    modport slave  (input req, len0, len1, output grant, cnt_en, count, done, busy);
`endif
endinterface

// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter granting bursts of a shared counter to two requesters.
// Optional feature: define COUNTER_ARB_ABORT_EN to let bus.abort end a running burst early.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  counter_arb_if.slave (req, len0, len1, [abort] in; grant, cnt_en, count, done, busy out)
module counter_arb #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input logic         clk,
    input logic         rst,
    counter_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] count;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             ptr;
    logic             run_en;
    logic             win;
    logic [LEN_W-1:0] win_len;
    logic             stop;
    // The pointer only matters on contention; a lone requester always wins.
    always_comb begin
        win     = (bus.req == 2'b11) ? ptr : bus.req[1];
        win_len = win ? bus.len1 : bus.len0;
    end
`ifdef COUNTER_ARB_ABORT_EN
    assign stop = bus.abort;
`else
    assign stop = 1'b0;
`endif
    // Abort must kill the enable in the same cycle, so it gates the registered enable.
    assign bus.cnt_en = run_en & ~stop;
    assign bus.busy   = state != IDLE;
    assign bus.count  = count;
    assign bus.grant  = grant;
    assign bus.done   = done;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            count     <= '0;
            grant     <= 2'b00;
            done      <= 2'b00;
            ptr       <= 1'b0;
            run_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    grant     <= win ? 2'b10 : 2'b01;
                    remaining <= win_len;
                    run_en    <= win_len != '0;
                    // A zero-length burst skips RUN and signals done straight away.
                    done      <= (win_len == '0) ? (win ? 2'b10 : 2'b01) : 2'b00;
                    state     <= (win_len != '0) ? RUN : DONE;
                end
                RUN: begin
                    if (bus.cnt_en) count <= count + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (stop || remaining == LEN_W'(1)) begin
                        run_en <= 1'b0;
                        done   <= grant;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= ~grant[1];
                    grant <= 2'b00;
                    done  <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_arb.sv
// tb_counter_arb: randomized scoreboard bench for counter_arb against a burst-level reference model.
// Honours COUNTER_ARB_ABORT_EN when the design is built with it.
module tb_counter_arb;
    localparam int WIDTH = 4;
    localparam int LEN_W = 4;
    localparam int MOD = 1 << WIDTH;
    typedef struct {
        int owner;
        int len;
        int cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    counter_arb_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();
    counter_arb #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    // Reference model: one arbitration decision per idle edge; a granted burst of length L
    // occupies L RUN edges plus one DONE edge before the next decision can be made.
    int   m_left = 0;
    int   m_ptr = 0;
    int   m_count = 0;
    int   mw, ml;
    exp_t me;
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_ptr = 0;
            m_count = 0;
            q.delete();
        end else if (m_left == 0) begin
            if (bus.req != 2'b00) begin
                mw = (bus.req == 2'b11) ? m_ptr : int'(bus.req[1]);
                ml = mw ? int'(bus.len1) : int'(bus.len0);
                m_count = (m_count + ml) % MOD;
                q.push_back('{mw, ml, m_count});
                m_left = ml + 1;
                m_ptr = 1 - mw;
            end
        end else begin
`ifdef COUNTER_ARB_ABORT_EN
            if (m_left >= 2 && bus.abort) begin
                me = q.pop_back();
                me.len = me.len - (m_left - 1);
                m_count = (m_count - (m_left - 1) + MOD) % MOD;
                me.cnt = m_count;
                q.push_back(me);
                m_left = 1;
            end else
                m_left = m_left - 1;
`else
            m_left = m_left - 1;
`endif
        end
    end
    // Monitor: samples just after the falling edge, once inputs for the cycle are settled.
    int   en_cycles = 0;
    int   prev_count = 0;
    int   prev_en = 0;
    exp_t got;
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk("rst_grant", bus.grant, 0);
            chk("rst_cnt_en", bus.cnt_en, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_count", bus.count, 0);
            en_cycles = 0;
            prev_count = 0;
            prev_en = 0;
        end else begin
            chk("count_step", bus.count, (prev_count + prev_en) % MOD);
            chk("busy_vs_grant", bus.busy, int'(bus.grant != 2'b00));
            if (bus.grant != 2'b00 && q.size() > 0)
                chk("grant_owner", bus.grant, 1 << q[0].owner);
            if (bus.cnt_en) en_cycles++;
            if (bus.done != 2'b00) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=%0d with no burst expected (t=%0t)", bus.done, $time);
                end else begin
                    got = q.pop_front();
                    chk("done_owner", bus.done, 1 << got.owner);
                    chk("done_count", bus.count, got.cnt);
                    chk("burst_len", en_cycles, got.len);
                end
                en_cycles = 0;
            end
            prev_count = int'(bus.count);
            prev_en = int'(bus.cnt_en);
        end
    end
    task automatic drive(input logic [1:0] r, input int l0, input int l1);
        bus.req = r;
        bus.len0 = LEN_W'(l0);
        bus.len1 = LEN_W'(l1);
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        drive(2'b00, 0, 0);
`ifdef COUNTER_ARB_ABORT_EN
        bus.abort = 1'b0;
`endif
        wait_n(3);
        rst = 1'b0;
        // single burst, len0=5
        drive(2'b01, 5, 0);
        wait_n(1);
        drive(2'b00, 9, 9);
        wait_n(10);
        // contention, alternating owners
        drive(2'b11, 2, 3);
        wait_n(14);
        drive(2'b00, 0, 0);
        wait_n(8);
        // zero-length burst
        drive(2'b10, 0, 0);
        wait_n(1);
        drive(2'b00, 0, 0);
        wait_n(5);
        // wrap across 4'hF
        drive(2'b01, 4, 0);
        wait_n(1);
        drive(2'b00, 0, 0);
        wait_n(8);
        // reset in the middle of a burst, then re-grant
        drive(2'b01, 6, 0);
        wait_n(1);
        drive(2'b00, 0, 0);
        wait_n(2);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        drive(2'b01, 3, 0);
        wait_n(1);
        drive(2'b00, 0, 0);
        wait_n(8);
`ifdef COUNTER_ARB_ABORT_EN
        drive(2'b01, 8, 0);
        wait_n(1);
        drive(2'b00, 0, 0);
        wait_n(1);
        bus.abort = 1'b1;
        wait_n(1);
        bus.abort = 1'b0;
        wait_n(6);
`endif
        // randomized traffic, with lengths changing every cycle
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
                  $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
`ifdef COUNTER_ARB_ABORT_EN
            bus.abort = ($urandom_range(0, 15) == 0);
`endif
            rst = ($urandom_range(0, 499) == 0);
            wait_n(1);
        end
        rst = 1'b0;
        drive(2'b00, 0, 0);
`ifdef COUNTER_ARB_ABORT_EN
        bus.abort = 1'b0;
`endif
        wait_n(40);
        chk("drain_queue", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
